// File: rtl/activ_ctrl_pkg.sv
// rtl/activ_ctrl_pkg.sv - shared types and default sizes for the activation SR sequencer
package activ_ctrl_pkg;

  localparam int PA    = 8;
  localparam int W_CNT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    CLEAR = 2'd3
  } activ_state_t;

endpackage

// File: rtl/activ_sr_ctrl_if.sv
// rtl/activ_sr_ctrl_if.sv - job, activation handshake and SR control bundle
interface activ_sr_ctrl_if #(
  parameter int Pa    = activ_ctrl_pkg::PA,
  parameter int W_CNT = activ_ctrl_pkg::W_CNT
);
  localparam int IW = $clog2(Pa);

  logic             start;
  logic             abort;
  logic [W_CNT-1:0] cfg_words;
  logic             act_valid;
  logic             act_ready;
  logic             smac_ready;
  logic             sr_w_en;
  logic             sr_s_en;
  logic             sr_cl_en;
  logic             bit_valid;
  logic [IW-1:0]    bit_idx;
  logic             bit_last;
  logic             word_last;
  logic             busy;
  logic             done;

  // master = the sequencer, slave = job source / SR bank / SMAC side
  modport master (
    input  start, abort, cfg_words, act_valid, smac_ready,
    output act_ready, sr_w_en, sr_s_en, sr_cl_en, bit_valid,
           bit_idx, bit_last, word_last, busy, done
  );

  modport slave (
    output start, abort, cfg_words, act_valid, smac_ready,
    input  act_ready, sr_w_en, sr_s_en, sr_cl_en, bit_valid,
           bit_idx, bit_last, word_last, busy, done
  );

endinterface

// File: rtl/activ_bit_cnt.sv
// rtl/activ_bit_cnt.sv - modulo-Pa bit position counter for the activation shift
module activ_bit_cnt #(
  parameter int Pa = activ_ctrl_pkg::PA,
  localparam int IW = $clog2(Pa)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [IW-1:0] bit_idx,
  output logic          bit_last
);

  localparam logic [IW-1:0] LAST = IW'(Pa - 1);

  logic [IW-1:0] cnt_q;
  logic [IW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_idx  = cnt_q;
  assign bit_last = (cnt_q == LAST);

endmodule

// File: rtl/activ_sr_ctrl.sv
// rtl/activ_sr_ctrl.sv - load/shift/clear sequencer for the activation shift-register bank
module activ_sr_ctrl #(
  parameter int Pa    = activ_ctrl_pkg::PA,
  parameter int W_CNT = activ_ctrl_pkg::W_CNT
) (
  input  logic            clk,
  input  logic            rst_n,
  activ_sr_ctrl_if.master bus
);
  import activ_ctrl_pkg::*;

  localparam int IW = $clog2(Pa);

  activ_state_t     state_q, state_d;
  logic [W_CNT-1:0] words_left_q, words_left_d;

  logic          cnt_clr;
  logic          cnt_inc;
  logic [IW-1:0] cnt_idx;
  logic          cnt_last;

  logic act_ready_c;
  logic w_en_c;
  logic s_en_c;
  logic cl_en_c;
  logic bit_valid_c;
  logic done_c;

  activ_bit_cnt #(.Pa(Pa)) u_bit_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .bit_idx  (cnt_idx),
    .bit_last (cnt_last)
  );

  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    act_ready_c  = 1'b0;
    w_en_c       = 1'b0;
    s_en_c       = 1'b0;
    cl_en_c      = 1'b0;
    bit_valid_c  = 1'b0;
    done_c       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          cnt_clr = 1'b1;
          if (bus.cfg_words == '0) begin
            state_d = CLEAR;
          end else begin
            words_left_d = bus.cfg_words;
            state_d      = LOAD;
          end
        end
      end

      LOAD: begin
        if (bus.abort) begin
          cnt_clr = 1'b1;
          state_d = CLEAR;
        end else begin
          act_ready_c = 1'b1;
          w_en_c      = bus.act_valid;
          if (bus.act_valid) begin
            cnt_clr      = 1'b1;
            words_left_d = words_left_q - W_CNT'(1);
            state_d      = SHIFT;
          end
        end
      end

      SHIFT: begin
        bit_valid_c = 1'b1;
        if (bus.abort) begin
          cnt_clr = 1'b1;
          state_d = CLEAR;
        end else if (bus.smac_ready) begin
          if (!cnt_last) begin
            s_en_c  = 1'b1;
            cnt_inc = 1'b1;
          end else if (words_left_q != '0 && bus.act_valid) begin
            // sign bit leaves as the next word lands: no bubble between words
            w_en_c       = 1'b1;
            act_ready_c  = 1'b1;
            cnt_clr      = 1'b1;
            words_left_d = words_left_q - W_CNT'(1);
          end else if (words_left_q != '0) begin
            s_en_c  = 1'b1;
            state_d = LOAD;
          end else begin
            s_en_c  = 1'b1;
            state_d = CLEAR;
          end
        end
      end

      CLEAR: begin
        cl_en_c = 1'b1;
        done_c  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      words_left_q <= '0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
    end
  end

  assign bus.act_ready = act_ready_c;
  assign bus.sr_w_en   = w_en_c;
  assign bus.sr_s_en   = s_en_c;
  assign bus.sr_cl_en  = cl_en_c;
  assign bus.bit_valid = bit_valid_c;
  assign bus.done      = done_c;
  assign bus.busy      = (state_q != IDLE);
  assign bus.bit_idx   = (state_q == SHIFT) ? cnt_idx : '0;
  assign bus.bit_last  = (state_q == SHIFT) && cnt_last;
  assign bus.word_last = (state_q == SHIFT) && (words_left_q == '0);

endmodule
